// File: rtl/uart_echo_fifo.sv
// Echo buffer between UART RX and TX: a FIFO feeding one output register,
// with optional ASCII case folding, flush and a saturating drop counter.
module uart_echo_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 8,
  parameter int CASE_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic [1:0]                 mode,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic [CNT_W-1:0]           ovf_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] wr_data;
  logic [8:0]        ext;
  logic              hs;
  logic              pop;
  logic              push;
  logic              drop;
  logic [LW-1:0]     level_nxt;
  logic              tx_valid_nxt;

  // Case folding of the incoming word, only meaningful for 8-bit ASCII
  always_comb begin
    ext     = 9'(rx_data);
    wr_data = rx_data;
    if (CASE_EN == 1 && DATA_W == 8) begin
      unique case (1'b1)
        (mode == 2'b01) && (ext >= 9'h061) && (ext <= 9'h07a):
          wr_data = DATA_W'(ext - 9'h020);
        (mode == 2'b10) && (ext >= 9'h041) && (ext <= 9'h05a):
          wr_data = DATA_W'(ext + 9'h020);
        default: ;
      endcase
    end
  end

  // Push/pop/drop decisions and the next occupancy state
  always_comb begin
    hs   = tx_valid && tx_ready;
    pop  = (level != '0) && (!tx_valid || tx_ready);
    push = rx_valid && (!full || pop);
    drop = rx_valid && !push && !flush;
    level_nxt = level;
    tx_valid_nxt = tx_valid;
    if (flush) begin
      level_nxt    = '0;
      tx_valid_nxt = 1'b0;
    end else begin
      if (push && !pop)
        level_nxt = level + LW'(1);
      else if (pop && !push)
        level_nxt = level - LW'(1);
      if (pop)
        tx_valid_nxt = 1'b1;
      else if (hs)
        tx_valid_nxt = 1'b0;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers, output register and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      level    <= level_nxt;
      tx_valid <= tx_valid_nxt;
      empty    <= (level_nxt == '0) && !tx_valid_nxt;
      full     <= (level_nxt == LW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          tx_data <= mem[rd_ptr];
        end
      end
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (clr_err) begin
      overflow <= drop;
      ovf_cnt  <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: echo, case folding, fill/drop,
// simultaneous push/pop, counter saturation, flush and async reset.
module tb_uart_echo_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [1:0] mode;
  logic       flush;
  logic       clr_err;

  logic [7:0] tx_data, tx_data_s;
  logic       tx_valid, tx_valid_s;
  logic [4:0] level, level_s;
  logic       empty, empty_s;
  logic       full, full_s;
  logic       overflow, overflow_s;
  logic [7:0] ovf_cnt;
  logic [1:0] ovf_cnt_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_echo_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mode(mode), .flush(flush), .clr_err(clr_err),
    .level(level), .empty(empty), .full(full),
    .overflow(overflow), .ovf_cnt(ovf_cnt)
  );

  uart_echo_fifo #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready),
    .mode(mode), .flush(flush), .clr_err(clr_err),
    .level(level_s), .empty(empty_s), .full(full_s),
    .overflow(overflow_s), .ovf_cnt(ovf_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  // Requires tx_ready=1: wait for a word, check it, let it hand off
  task automatic expect_word(input string tag, input logic [7:0] d);
    for (int i = 0; i < 20 && !tx_valid; i++)
      step();
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk(tag, 32'(tx_data), 32'(d));
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data), 32'd0);
    chk({tag, "_lvl"}, 32'(level), 32'd0);
    chk({tag, "_emp"}, 32'(empty), 32'd1);
    chk({tag, "_ful"}, 32'(full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_cnt"}, 32'(ovf_cnt), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    mode     = 2'b00;
    flush    = 1'b0;
    clr_err  = 1'b0;
    step();
    step();
    chk_reset("rst");
    #2 rst_n = 1'b1;
    step();
    chk("rst_hold_emp", 32'(empty), 32'd1);

    // Single echo
    tx_ready = 1'b1;
    push(8'h41);
    chk("echo_lvl1", 32'(level), 32'd1);
    chk("echo_txv0", 32'(tx_valid), 32'd0);
    chk("echo_emp0", 32'(empty), 32'd0);
    step();
    chk("echo_txv1", 32'(tx_valid), 32'd1);
    chk("echo_txd", 32'(tx_data), 32'h41);
    chk("echo_lvl0", 32'(level), 32'd0);
    step();
    chk("echo_done_txv", 32'(tx_valid), 32'd0);
    chk("echo_done_emp", 32'(empty), 32'd1);

    // Case folding
    tx_ready = 1'b0;
    mode = 2'b01;
    push(8'h61);
    push(8'h7a);
    push(8'h31);
    mode = 2'b00;
    tx_ready = 1'b1;
    expect_word("up_a", 8'h41);
    expect_word("up_z", 8'h5a);
    expect_word("up_1", 8'h31);
    tx_ready = 1'b0;
    mode = 2'b10;
    push(8'h41);
    push(8'h5b);
    mode = 2'b00;
    tx_ready = 1'b1;
    expect_word("lo_A", 8'h61);
    expect_word("lo_brk", 8'h5b);

    // Fill under backpressure, drop the 18th
    tx_ready = 1'b0;
    for (int i = 1; i <= 18; i++)
      push(8'(8'h10 + i));
    chk("fill_lvl", 32'(level), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_cnt", 32'(ovf_cnt), 32'd1);
    chk("fill_txv", 32'(tx_valid), 32'd1);
    chk("fill_txd", 32'(tx_data), 32'h11);

    // Simultaneous push and pop at full
    tx_ready = 1'b1;
    push(8'h55);
    chk("pp_lvl", 32'(level), 32'd16);
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_cnt", 32'(ovf_cnt), 32'd1);
    for (int i = 2; i <= 17; i++)
      expect_word("drain", 8'(8'h10 + i));
    expect_word("drain_55", 8'h55);
    chk("drain_txv", 32'(tx_valid), 32'd0);
    chk("drain_emp", 32'(empty), 32'd1);

    // Counter saturation and clear
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr0_ovf", 32'(overflow), 32'd0);
    chk("clr0_cnt", 32'(ovf_cnt), 32'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 22; i++)
      push(8'(i));
    chk("sat_cnt_s", 32'(ovf_cnt_s), 32'd3);
    chk("sat_cnt", 32'(ovf_cnt), 32'd5);
    chk("sat_ovf_s", 32'(overflow_s), 32'd1);
    clr_err = 1'b1;
    step();
    chk("clr_cnt_s", 32'(ovf_cnt_s), 32'd0);
    chk("clr_ovf_s", 32'(overflow_s), 32'd0);
    chk("clr_cnt", 32'(ovf_cnt), 32'd0);
    push(8'h99);
    clr_err = 1'b0;
    chk("clrdrop_cnt_s", 32'(ovf_cnt_s), 32'd1);
    chk("clrdrop_ovf_s", 32'(overflow_s), 32'd1);
    chk("clrdrop_cnt", 32'(ovf_cnt), 32'd1);

    // Flush
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl0_lvl", 32'(level), 32'd0);
    chk("fl0_txv", 32'(tx_valid), 32'd0);
    chk("fl0_emp", 32'(empty), 32'd1);
    chk("fl0_full", 32'(full), 32'd0);
    for (int i = 0; i < 5; i++)
      push(8'(8'h30 + i));
    chk("fl_pre_lvl", 32'(level), 32'd4);
    chk("fl_pre_txv", 32'(tx_valid), 32'd1);
    flush = 1'b1;
    push(8'h7e);
    flush = 1'b0;
    chk("fl_lvl", 32'(level), 32'd0);
    chk("fl_txv", 32'(tx_valid), 32'd0);
    chk("fl_cnt", 32'(ovf_cnt), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    step();
    step();
    step();
    chk("fl_after_txv", 32'(tx_valid), 32'd0);
    chk("fl_after_emp", 32'(empty), 32'd1);

    // Asynchronous reset mid-drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(8'(8'h60 + i));
    tx_ready = 1'b1;
    step();
    chk("ar_pre_txv", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("ar");
    step();
    #2 rst_n = 1'b1;
    step();
    step();
    chk("ar_post_txv", 32'(tx_valid), 32'd0);
    chk("ar_post_lvl", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
